nubus_master: RTL and testbench

- NuBus master (initiator) controller.
- Takes single-beat requests from a local memory-style port, arbitrates for the bus, and issues the start/address cycle with TM encoding.
- Drives write data or captures read data, then terminates on the slave's ACK with status decode and bounded try-again retries.
- Companion of the card's slave controller, which pairs with it at the other end of each transfer. All NuBus-side signals are active-low, and the bus carries inverted address/data.

---
 rtl/nubus_master_if.sv | 45 ++++
 rtl/nubus_master.sv | 209 ++++++++++++++++++++
 tb/tb_nubus_master.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nubus_master_if.sv
// NuBus master signal bundle: local request port plus NuBus sample/drive lines.
// The master modport is the controller's view; slave is the card/bench side.
interface nubus_master_if;
    logic [3:0]  nub_idn;
    logic        cpu_valid;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_write;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic        nub_startn_i;
    logic        nub_ackn_i;
    logic        nub_tm1n_i;
    logic        nub_tm0n_i;
    logic [31:0] nub_adn_i;
    logic [3:0]  nub_arbn_i;
    logic        nub_startn_o;
    logic        nub_tm1n_o;
    logic        nub_tm0n_o;
    logic        nub_ctl_oe;
    logic [31:0] nub_adn_o;
    logic        nub_ad_oe;
    logic        nub_rqstn_o;
    logic [3:0]  nub_arbn_o;
    logic        master_o;

    modport master (
        input  nub_idn, cpu_valid, cpu_addr, cpu_wdata, cpu_write,
        input  nub_startn_i, nub_ackn_i, nub_tm1n_i, nub_tm0n_i,
        input  nub_adn_i, nub_arbn_i,
        output cpu_ready, cpu_rdata, cpu_err,
        output nub_startn_o, nub_tm1n_o, nub_tm0n_o, nub_ctl_oe,
        output nub_adn_o, nub_ad_oe, nub_rqstn_o, nub_arbn_o, master_o
    );

    modport slave (
        output nub_idn, cpu_valid, cpu_addr, cpu_wdata, cpu_write,
        output nub_startn_i, nub_ackn_i, nub_tm1n_i, nub_tm0n_i,
        output nub_adn_i, nub_arbn_i,
        input  cpu_ready, cpu_rdata, cpu_err,
        input  nub_startn_o, nub_tm1n_o, nub_tm0n_o, nub_ctl_oe,
        input  nub_adn_o, nub_ad_oe, nub_rqstn_o, nub_arbn_o, master_o
    );
endinterface

// File: rtl/nubus_master.sv
// NuBus master: arbitrate, START/address, data, ACK status with try-again retry.
// Define NUBUS_MASTER_TIMEOUT_EN to abort the data phase after TIMEOUT_CYCLES.
module nubus_master #(
    parameter int RETRY_MAX  = 3,
    parameter int ARB_CYCLES = 2
`ifdef NUBUS_MASTER_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic clk,
    input  logic reset,
    nubus_master_if.master bus
);
    localparam int AW = (ARB_CYCLES > 1) ? $clog2(ARB_CYCLES) : 1;
    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_START, S_DATA} state_t;

    state_t          state, state_n;
    logic [31:0]     addr_q, wdata_q, rdata_q;
    logic            rd_q, tm1n_q, tm0n_q;
    logic [AW-1:0]   arb_cnt;
    logic [RW-1:0]   retry_q;
    logic            lost_q, busy_q, ready_q, err_q;

    logic            enc_ok, enc_tm1n, enc_tm0n;
    logic [1:0]      enc_lo;
    logic            ack, settled, won, tmo_hit;
    logic [1:0]      stat;
    logic [3:0]      arb_drv;
    logic            accept, bad, done, fail, retry;

    assign ack     = ~bus.nub_ackn_i;
    assign stat    = {~bus.nub_tm1n_i, ~bus.nub_tm0n_i};
    assign settled = (arb_cnt == AW'(ARB_CYCLES - 1));
    assign won     = (bus.nub_arbn_i == bus.nub_idn) && !busy_q;

    always_comb begin
        enc_ok   = 1'b1;
        enc_lo   = 2'b00;
        enc_tm1n = 1'b0;
        enc_tm0n = 1'b1;
        case (bus.cpu_write)
            4'b1111: enc_lo = 2'b00;
            4'b1100: enc_lo = 2'b11;
            4'b0011: enc_lo = 2'b01;
            4'b0001: begin enc_lo = 2'b00; enc_tm0n = 1'b0; end
            4'b0010: begin enc_lo = 2'b01; enc_tm0n = 1'b0; end
            4'b0100: begin enc_lo = 2'b10; enc_tm0n = 1'b0; end
            4'b1000: begin enc_lo = 2'b11; enc_tm0n = 1'b0; end
            4'b0000: enc_tm1n = 1'b1;
            default: enc_ok = 1'b0;
        endcase
    end

    // A lower ARB bit competes only while every higher bit still matches our ID.
    always_comb begin
        arb_drv[3] = bus.nub_idn[3];
        arb_drv[2] = (bus.nub_arbn_i[3] == bus.nub_idn[3]) ? bus.nub_idn[2] : 1'b1;
        arb_drv[1] = (bus.nub_arbn_i[3:2] == bus.nub_idn[3:2]) ? bus.nub_idn[1] : 1'b1;
        arb_drv[0] = (bus.nub_arbn_i[3:1] == bus.nub_idn[3:1]) ? bus.nub_idn[0] : 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n          = state;
        accept           = 1'b0;
        bad              = 1'b0;
        done             = 1'b0;
        fail             = 1'b0;
        retry            = 1'b0;
        bus.nub_startn_o = 1'b1;
        bus.nub_tm1n_o   = 1'b1;
        bus.nub_tm0n_o   = 1'b1;
        bus.nub_ctl_oe   = 1'b0;
        bus.nub_adn_o    = '1;
        bus.nub_ad_oe    = 1'b0;
        bus.nub_rqstn_o  = 1'b1;
        bus.nub_arbn_o   = 4'hF;
        bus.master_o     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.cpu_valid && !ready_q) begin
                    accept = 1'b1;
                    if (enc_ok) state_n = S_ARB;
                    else        bad     = 1'b1;
                end
            end
            S_ARB: begin
                bus.nub_rqstn_o = 1'b0;
                bus.nub_arbn_o  = arb_drv;
                if (!lost_q && settled && won) state_n = S_START;
            end
            S_START: begin
                bus.nub_startn_o = 1'b0;
                bus.nub_tm1n_o   = tm1n_q;
                bus.nub_tm0n_o   = tm0n_q;
                bus.nub_ctl_oe   = 1'b1;
                bus.nub_adn_o    = ~addr_q;
                bus.nub_ad_oe    = 1'b1;
                bus.master_o     = 1'b1;
                state_n          = S_DATA;
            end
            S_DATA: begin
                bus.master_o  = 1'b1;
                bus.nub_ad_oe = ~rd_q;
                bus.nub_adn_o = rd_q ? '1 : ~wdata_q;
                if (ack) begin
                    unique case (stat)
                        2'b00: done = 1'b1;
                        2'b11: begin
                            if (retry_q == RW'(RETRY_MAX)) begin
                                done = 1'b1;
                                fail = 1'b1;
                            end else begin
                                retry   = 1'b1;
                                state_n = S_ARB;
                            end
                        end
                        default: begin
                            done = 1'b1;
                            fail = 1'b1;
                        end
                    endcase
                end else if (tmo_hit) begin
                    done = 1'b1;
                    fail = 1'b1;
                end
                if (done) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            tm1n_q  <= 1'b1;
            tm0n_q  <= 1'b1;
            arb_cnt <= '0;
            lost_q  <= 1'b0;
            retry_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            ready_q <= done | bad;
            err_q   <= fail | bad;
            if (done && !fail && rd_q) rdata_q <= ~bus.nub_adn_i;
            if (accept) begin
                addr_q  <= {bus.cpu_addr[31:2], enc_lo};
                wdata_q <= bus.cpu_wdata;
                rd_q    <= (bus.cpu_write == 4'b0000);
                tm1n_q  <= enc_tm1n;
                tm0n_q  <= enc_tm0n;
            end
            // After a lost round, hold off until the current owner's ACK.
            if (state == S_ARB) begin
                if (lost_q) begin
                    if (ack) begin
                        lost_q  <= 1'b0;
                        arb_cnt <= '0;
                    end
                end else if (settled) begin
                    if (!won) begin
                        lost_q  <= 1'b1;
                        arb_cnt <= '0;
                    end
                end else begin
                    arb_cnt <= arb_cnt + 1'b1;
                end
            end else begin
                lost_q  <= 1'b0;
                arb_cnt <= '0;
            end
            if (done)       retry_q <= '0;
            else if (retry) retry_q <= retry_q + 1'b1;
            if (ack || tmo_hit)          busy_q <= 1'b0;
            else if (!bus.nub_startn_i)  busy_q <= 1'b1;
        end
    end

`ifdef NUBUS_MASTER_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TW-1:0] tmo_q;

    // Counts from the START cycle so the abort lands TIMEOUT_CYCLES after it.
    assign tmo_hit = (state == S_DATA) && !ack && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                     tmo_q <= '0;
        else if (state == S_START || state == S_DATA)  tmo_q <= tmo_q + 1'b1;
        else                                           tmo_q <= '0;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign bus.cpu_ready = ready_q;
    assign bus.cpu_err   = err_q;
    assign bus.cpu_rdata = rdata_q;
endmodule

// File: tb/tb_nubus_master.sv
// Scoreboard bench for nubus_master: a responder ACKs each START with queued status.
// Timeout scenario is built only when NUBUS_MASTER_TIMEOUT_EN is defined.
module tb_nubus_master;
    localparam int ARB  = 2;
    localparam int RMAX = 3;

    typedef struct {
        logic        chk_rd;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    nubus_master_if bus();

`ifdef NUBUS_MASTER_TIMEOUT_EN
    nubus_master #(.RETRY_MAX(RMAX), .ARB_CYCLES(ARB), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .bus(bus));
`else
    nubus_master #(.RETRY_MAX(RMAX), .ARB_CYCLES(ARB)) dut (
        .clk(clk), .reset(reset), .bus(bus));
`endif

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0;
    int fails = 0;
    exp_t sb[$];

    logic        cpu_valid = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [3:0]  cpu_write = '0;
    logic        ext_ackn = 1'b1;
    logic        ext_startn = 1'b1;
    logic        resp_ackn = 1'b1;
    logic        resp_tm1n = 1'b1;
    logic        resp_tm0n = 1'b1;
    logic [31:0] resp_adn = '1;
    logic [3:0]  arb_in = 4'h1;

    assign bus.nub_idn      = 4'h1;
    assign bus.cpu_valid    = cpu_valid;
    assign bus.cpu_addr     = cpu_addr;
    assign bus.cpu_wdata    = cpu_wdata;
    assign bus.cpu_write    = cpu_write;
    assign bus.nub_startn_i = ext_startn;
    assign bus.nub_ackn_i   = ext_ackn & resp_ackn;
    assign bus.nub_tm1n_i   = resp_tm1n;
    assign bus.nub_tm0n_i   = resp_tm0n;
    assign bus.nub_adn_i    = resp_adn;
    assign bus.nub_arbn_i   = arb_in;

    logic        resp_en = 1'b1;
    logic [1:0]  stat_q[$];
    logic [31:0] resp_rdata = '0;
    int          start_cnt = 0;
    int          st_cyc = 0;
    logic [31:0] st_adn, dt_adn;
    logic        st_tm1n, st_tm0n, dt_oe;

    // Slave model: ACK in the cycle after each START with the next queued status.
    always @(negedge clk) begin
        logic [1:0] s;
        if (bus.nub_ctl_oe && !bus.nub_startn_o) begin
            start_cnt++;
            st_cyc  = cyc;
            st_adn  = bus.nub_adn_o;
            st_tm1n = bus.nub_tm1n_o;
            st_tm0n = bus.nub_tm0n_o;
            if (resp_en) begin
                s = (stat_q.size() > 0) ? stat_q.pop_front() : 2'b00;
                @(posedge clk); #1;
                resp_ackn = 1'b0;
                resp_tm1n = ~s[1];
                resp_tm0n = ~s[0];
                resp_adn  = ~resp_rdata;
                @(negedge clk);
                dt_adn = bus.nub_adn_o;
                dt_oe  = bus.nub_ad_oe;
                @(posedge clk); #1;
                resp_ackn = 1'b1;
                resp_tm1n = 1'b1;
                resp_tm0n = 1'b1;
                resp_adn  = '1;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int t0);
        @(posedge clk); #1;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_write = s;
        cpu_valid = 1'b1;
        t0 = cyc;
    endtask

    task automatic wait_ready(input int limit, output logic ok, output int tr,
                              output logic [31:0] rd, output logic er);
        ok = 1'b0; tr = 0; rd = '0; er = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.cpu_ready) begin
                ok = 1'b1; tr = cyc; rd = bus.cpu_rdata; er = bus.cpu_err;
                break;
            end
        end
        @(posedge clk); #1;
        cpu_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests++;
        if ({bus.cpu_ready, bus.cpu_err, bus.master_o} !== 3'b000) begin
            fails++;
            $display("FAIL rst_cpu: got %b want 000", {bus.cpu_ready, bus.cpu_err, bus.master_o});
        end
        tests++;
        if (bus.cpu_rdata !== 32'h0) begin
            fails++;
            $display("FAIL rst_rdata: got %h want 0", bus.cpu_rdata);
        end
        tests++;
        if ({bus.nub_startn_o, bus.nub_tm1n_o, bus.nub_tm0n_o, bus.nub_rqstn_o,
             bus.nub_arbn_o} !== 8'hFF) begin
            fails++;
            $display("FAIL rst_n: got %h want ff", {bus.nub_startn_o, bus.nub_tm1n_o,
                     bus.nub_tm0n_o, bus.nub_rqstn_o, bus.nub_arbn_o});
        end
        tests++;
        if ({bus.nub_ctl_oe, bus.nub_ad_oe} !== 2'b00 || bus.nub_adn_o !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL rst_oe: got oe=%b adn=%h want oe=00 adn=ffffffff",
                     {bus.nub_ctl_oe, bus.nub_ad_oe}, bus.nub_adn_o);
        end
        reset = 1'b0;
    endtask

    task automatic test_word_write;
        int t0, tr, s0; logic ok, er; logic [31:0] rd; exp_t e;
        s0 = start_cnt;
        sb.push_back('{1'b0, 32'h0, 1'b0});
        issue(32'hFE00_0010, 32'hDEAD_BEEF, 4'b1111, t0);
        wait_ready(50, ok, tr, rd, er);
        e = sb.pop_front();
        tests++;
        if (!ok || tr - t0 != ARB + 3) begin
            fails++;
            $display("FAIL wr_latency: got ok=%0b %0d want %0d", ok, tr - t0, ARB + 3);
        end
        tests++;
        if (er !== e.err) begin fails++; $display("FAIL wr_err: got %b want %b", er, e.err); end
        tests++;
        if (st_adn !== ~32'hFE00_0010 || {st_tm1n, st_tm0n} !== 2'b01) begin
            fails++;
            $display("FAIL wr_start: got adn=%h tm=%b want %h tm=01", st_adn,
                     {st_tm1n, st_tm0n}, ~32'hFE00_0010);
        end
        tests++;
        if (dt_adn !== ~32'hDEAD_BEEF || dt_oe !== 1'b1) begin
            fails++;
            $display("FAIL wr_data: got adn=%h oe=%b want %h oe=1", dt_adn, dt_oe, ~32'hDEAD_BEEF);
        end
        tests++;
        if (start_cnt - s0 != 1) begin
            fails++;
            $display("FAIL wr_starts: got %0d want 1", start_cnt - s0);
        end
    endtask

    task automatic test_word_read;
        int t0, tr; logic ok, er; logic [31:0] rd; exp_t e;
        resp_rdata = 32'h1234_5678;
        sb.push_back('{1'b1, 32'h1234_5678, 1'b0});
        issue(32'hF900_0000, 32'h0, 4'b0000, t0);
        wait_ready(50, ok, tr, rd, er);
        e = sb.pop_front();
        tests++;
        if (!ok || (e.chk_rd && rd !== e.rdata) || er !== e.err) begin
            fails++;
            $display("FAIL rd_data: got ok=%0b rdata=%h err=%b want %h err=%b",
                     ok, rd, er, e.rdata, e.err);
        end
        tests++;
        if ({st_tm1n, st_tm0n} !== 2'b11 || st_adn !== ~32'hF900_0000) begin
            fails++;
            $display("FAIL rd_start: got adn=%h tm=%b want %h tm=11", st_adn,
                     {st_tm1n, st_tm0n}, ~32'hF900_0000);
        end
        tests++;
        if (dt_oe !== 1'b0) begin fails++; $display("FAIL rd_ad_oe: got %b want 0", dt_oe); end
    endtask

    task automatic test_byte;
        int t0, tr, s0; logic ok, er; logic [31:0] rd; exp_t e;
        sb.push_back('{1'b0, 32'h0, 1'b0});
        issue(32'hF000_0000, 32'h00AB_0000, 4'b0100, t0);
        wait_ready(50, ok, tr, rd, er);
        e = sb.pop_front();
        tests++;
        if (!ok || er !== e.err || st_adn !== ~32'hF000_0002 || {st_tm1n, st_tm0n} !== 2'b00) begin
            fails++;
            $display("FAIL byte_enc: got ok=%0b err=%b adn=%h tm=%b want adn=%h tm=00",
                     ok, er, st_adn, {st_tm1n, st_tm0n}, ~32'hF000_0002);
        end
        s0 = start_cnt;
        sb.push_back('{1'b0, 32'h0, 1'b1});
        issue(32'hF000_0000, 32'h0, 4'b0110, t0);
        wait_ready(20, ok, tr, rd, er);
        e = sb.pop_front();
        tests++;
        if (!ok || er !== e.err || tr - t0 != 1) begin
            fails++;
            $display("FAIL bad_strobe: got ok=%0b err=%b lat=%0d want err=%b lat=1",
                     ok, er, tr - t0, e.err);
        end
        repeat (6) @(negedge clk);
        tests++;
        if (start_cnt != s0) begin
            fails++;
            $display("FAIL bad_strobe_start: got %0d starts want 0", start_cnt - s0);
        end
    endtask

    task automatic test_arb_loss;
        int t0, tr, s0; logic ok, er; logic [31:0] rd; exp_t e;
        s0 = start_cnt;
        arb_in = 4'h0;
        sb.push_back('{1'b0, 32'h0, 1'b0});
        issue(32'hFE00_0020, 32'hCAFE_F00D, 4'b1111, t0);
        @(posedge clk); #1; ext_startn = 1'b0;
        @(posedge clk); #1; ext_startn = 1'b1;
        repeat (8) @(negedge clk);
        tests++;
        if (start_cnt != s0 || bus.nub_rqstn_o !== 1'b0 || bus.nub_arbn_o !== 4'h1) begin
            fails++;
            $display("FAIL arb_lost: got starts=%0d rqstn=%b arbn=%h want 0 0 1",
                     start_cnt - s0, bus.nub_rqstn_o, bus.nub_arbn_o);
        end
        arb_in = 4'h1;
        repeat (6) @(negedge clk);
        tests++;
        if (start_cnt != s0) begin
            fails++;
            $display("FAIL arb_wait_ack: got %0d starts want 0", start_cnt - s0);
        end
        @(posedge clk); #1; ext_ackn = 1'b0;
        @(posedge clk); #1; ext_ackn = 1'b1;
        wait_ready(50, ok, tr, rd, er);
        e = sb.pop_front();
        tests++;
        if (!ok || er !== e.err || start_cnt - s0 != 1) begin
            fails++;
            $display("FAIL arb_win: got ok=%0b err=%b starts=%0d want err=%b starts=1",
                     ok, er, start_cnt - s0, e.err);
        end
    endtask

    task automatic test_retry;
        int t0, tr, s0; logic ok, er; logic [31:0] rd; exp_t e;
        s0 = start_cnt;
        for (int i = 0; i <= RMAX; i++) stat_q.push_back(2'b11);
        sb.push_back('{1'b0, 32'h0, 1'b1});
        issue(32'hFE00_0030, 32'h1111_2222, 4'b1111, t0);
        wait_ready(100, ok, tr, rd, er);
        e = sb.pop_front();
        tests++;
        if (!ok || er !== e.err) begin
            fails++;
            $display("FAIL retry_err: got ok=%0b err=%b want err=%b", ok, er, e.err);
        end
        tests++;
        if (start_cnt - s0 != RMAX + 1 || stat_q.size() != 0) begin
            fails++;
            $display("FAIL retry_starts: got %0d want %0d", start_cnt - s0, RMAX + 1);
        end
    endtask

    task automatic test_status;
        int t0, tr, s0; logic ok, er; logic [31:0] rd; exp_t e;
        logic [1:0] codes [2];
        codes[0] = 2'b01;
        codes[1] = 2'b10;
        for (int k = 0; k < 2; k++) begin
            s0 = start_cnt;
            stat_q.push_back(codes[k]);
            sb.push_back('{1'b0, 32'h0, 1'b1});
            issue(32'hFE00_0040, 32'h0, 4'b1111, t0);
            wait_ready(50, ok, tr, rd, er);
            e = sb.pop_front();
            tests++;
            if (!ok || er !== e.err || start_cnt - s0 != 1) begin
                fails++;
                $display("FAIL status_%b: got ok=%0b err=%b starts=%0d want err=1 starts=1",
                         codes[k], ok, er, start_cnt - s0);
            end
        end
    endtask

`ifdef NUBUS_MASTER_TIMEOUT_EN
    task automatic test_timeout;
        int t0, tr; logic ok, er; logic [31:0] rd; exp_t e;
        resp_en = 1'b0;
        sb.push_back('{1'b0, 32'h0, 1'b1});
        issue(32'hFE00_0050, 32'h0, 4'b1111, t0);
        wait_ready(60, ok, tr, rd, er);
        e = sb.pop_front();
        tests++;
        if (!ok || er !== e.err || tr - st_cyc != 8) begin
            fails++;
            $display("FAIL timeout: got ok=%0b err=%b dist=%0d want err=1 dist=8",
                     ok, er, tr - st_cyc);
        end
        tests++;
        if ({bus.nub_ctl_oe, bus.nub_ad_oe, bus.master_o} !== 3'b000) begin
            fails++;
            $display("FAIL timeout_oe: got %b want 000", {bus.nub_ctl_oe, bus.nub_ad_oe, bus.master_o});
        end
        resp_en = 1'b1;
    endtask
`endif

    task automatic test_reset_mid;
        int t0, s0; logic seen;
        resp_en = 1'b0;
        s0 = start_cnt;
        issue(32'hF000_0100, 32'h55AA_55AA, 4'b1111, t0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (start_cnt > s0) break;
        end
        @(negedge clk);
        tests++;
        if (bus.master_o !== 1'b1 || bus.nub_ad_oe !== 1'b1) begin
            fails++;
            $display("FAIL mid_data: got master=%b oe=%b want 1 1", bus.master_o, bus.nub_ad_oe);
        end
        reset = 1'b1;
        #1;
        tests++;
        if ({bus.nub_ctl_oe, bus.nub_ad_oe, bus.master_o, bus.nub_rqstn_o, bus.nub_startn_o}
            !== 5'b00011 || bus.cpu_rdata !== 32'h0) begin
            fails++;
            $display("FAIL mid_reset: got %b rdata=%h want 00011 rdata=0",
                     {bus.nub_ctl_oe, bus.nub_ad_oe, bus.master_o, bus.nub_rqstn_o,
                      bus.nub_startn_o}, bus.cpu_rdata);
        end
        cpu_valid = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.cpu_ready) seen = 1'b1;
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.cpu_ready) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin fails++; $display("FAIL mid_ready: got 1 want 0"); end
        resp_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_word_write();
        test_word_read();
        test_byte();
        test_arb_loss();
        test_retry();
        test_status();
`ifdef NUBUS_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_left: got %0d want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
